// File: rtl/refresh_pkg.sv
// Shared types and helpers for the gain-cell refresh subsystem.
package refresh_pkg;

  // Geometry of each gain-cell memory wrapper.
  localparam int MEM_DEPTH = 128;
  localparam int MEM_WIDTH = 64;

  // Widest bank vector the one-hot helper can produce.
  localparam int MAX_BANKS = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_START,
    RS_REFRESH
  } ref_state_t;

  // One-hot decode of a bank index; callers truncate to their bank count.
  function automatic logic [MAX_BANKS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_BANKS'(1) << idx;
  endfunction

endpackage

// File: rtl/retention_timer.sv
// Free-running retention down-counter: pulses expire for one cycle every
// CYCLES enabled cycles, reloading itself on expiry. enable=0 freezes it.
module retention_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == '0);

  // Count down while enabled, reload on reaching zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= CW'(CYCLES - 1);
    end else if (enable) begin
      if (cnt == '0) cnt <= CW'(CYCLES - 1);
      else           cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Central refresh sequencer: on each retention request it refreshes one bank,
// walking the banks round-robin.
//
// Bank handshake: the scheduler announces a round with a 1-cycle start_sr
// pulse on the target bank, together with ref_en_current (target) and
// ref_en_old (previous bank). Enables are held until the wrapper answers with
// ref_done on the target bank (sampled only in REFRESH, never in START) or the
// timeout fires; the enables drop on the following edge and at least one IDLE
// cycle separates consecutive rounds.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int NUM_BANKS        = 4,
  parameter int RETENTION_CYCLES = 4096,
  parameter int REF_TIMEOUT      = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clr_err,
  input  logic [NUM_BANKS-1:0]         ref_done,
  output logic [NUM_BANKS-1:0]         start_sr,
  output logic [NUM_BANKS-1:0]         ref_en_current,
  output logic [NUM_BANKS-1:0]         ref_en_old,
  output logic [$clog2(NUM_BANKS)-1:0] cur_bank,
  output logic                         busy,
  output logic                         overrun,
  output logic                         ref_timeout,
  output ref_state_t                   state_dbg
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int TW = $clog2(REF_TIMEOUT);

  ref_state_t        state, state_nxt;
  logic [BW-1:0]     prev_bank;
  logic [TW-1:0]     tmo_cnt;
  logic              pending;
  logic              expire;
  logic              done_cur;
  logic              tmo_hit;
  logic              round_end;
  logic [NUM_BANKS-1:0] cur_oh, prev_oh;

  retention_timer #(
    .CYCLES (RETENTION_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .expire (expire)
  );

  assign done_cur  = ref_done[cur_bank];
  assign tmo_hit   = (tmo_cnt == TW'(REF_TIMEOUT - 1));
  assign round_end = (state == RS_REFRESH) && (done_cur || tmo_hit);
  assign cur_oh    = NUM_BANKS'(onehot(MAX_IDX_W'(cur_bank)));
  assign prev_oh   = NUM_BANKS'(onehot(MAX_IDX_W'(prev_bank)));
  assign state_dbg = state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RS_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: IDLE waits for a request, START lasts one cycle,
  // REFRESH ends on the target bank's done or on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      RS_IDLE:    if (pending) state_nxt = RS_START;
      RS_START:   state_nxt = RS_REFRESH;
      RS_REFRESH: if (done_cur || tmo_hit) state_nxt = RS_IDLE;
      default:    state_nxt = RS_IDLE;
    endcase
  end

  // FSM outputs: enables decoded from the bank pointers, zero in IDLE.
  always_comb begin
    start_sr       = '0;
    ref_en_current = '0;
    ref_en_old     = '0;
    busy           = 1'b0;
    case (state)
      RS_START: begin
        start_sr       = cur_oh;
        ref_en_current = cur_oh;
        ref_en_old     = prev_oh;
        busy           = 1'b1;
      end
      RS_REFRESH: begin
        ref_en_current = cur_oh;
        ref_en_old     = prev_oh;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  // Bank pointers advance at the end of every round, done or aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_bank  <= '0;
      prev_bank <= BW'(NUM_BANKS - 1);
    end else if (round_end) begin
      prev_bank <= cur_bank;
      cur_bank  <= (cur_bank == BW'(NUM_BANKS - 1)) ? '0 : cur_bank + BW'(1);
    end
  end

  // Per-round cycle counter, running only while in REFRESH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   tmo_cnt <= '0;
    else if (state == RS_REFRESH && !round_end) tmo_cnt <= tmo_cnt + TW'(1);
    else                                        tmo_cnt <= '0;
  end

  // Single-entry request latch: set on expiry, consumed when IDLE launches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 pending <= 1'b0;
    else if (expire)                          pending <= 1'b1;
    else if (state == RS_IDLE && pending)     pending <= 1'b0;
  end

  // Sticky error flags; a set event in the same cycle beats clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun     <= 1'b0;
      ref_timeout <= 1'b0;
    end else begin
      if (expire && (pending || state != RS_IDLE)) overrun <= 1'b1;
      else if (clr_err)                            overrun <= 1'b0;
      if (state == RS_REFRESH && tmo_hit && !done_cur) ref_timeout <= 1'b1;
      else if (clr_err)                                ref_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler with 4 banks, 16-cycle retention
// period and 140-cycle refresh timeout.
module tb_refresh_scheduler;
  import refresh_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clr_err;
  logic [3:0] ref_done;
  logic [3:0] start_sr;
  logic [3:0] ref_en_current;
  logic [3:0] ref_en_old;
  logic [1:0] cur_bank;
  logic       busy;
  logic       overrun;
  logic       ref_timeout;
  ref_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int overlap_err = 0;
  logic [3:0] last_cur = '0;

  refresh_scheduler #(
    .NUM_BANKS        (4),
    .RETENTION_CYCLES (16),
    .REF_TIMEOUT      (140)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .clr_err        (clr_err),
    .ref_done       (ref_done),
    .start_sr       (start_sr),
    .ref_en_current (ref_en_current),
    .ref_en_old     (ref_en_old),
    .cur_bank       (cur_bank),
    .busy           (busy),
    .overrun        (overrun),
    .ref_timeout    (ref_timeout),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach summary within time limit");
    $fatal(1, "watchdog expired");
  end

  // Mid-cycle monitor: current-bank enable must be one-hot and never switch
  // directly from one bank to another.
  always @(negedge clk) begin
    if (rst) begin
      if ($countones(ref_en_current) > 1) overlap_err++;
      if (ref_en_current != 4'b0 && last_cur != 4'b0 && ref_en_current != last_cur) overlap_err++;
      last_cur = ref_en_current;
    end else begin
      last_cur = 4'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (state_dbg != RS_START && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (state_dbg !== RS_START) begin
      n_err++;
      $display("FAIL %s_wait_start: state=%0d after %0d cycles, required START", tag, state_dbg, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; clr_err = 1'b0; ref_done = 4'b0;
    repeat (3) step();
    n_cmp++;
    if ({start_sr, ref_en_current, ref_en_old} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_enables: got %h required 000", {start_sr, ref_en_current, ref_en_old});
    end
    n_cmp++;
    if ({cur_bank, busy, overrun, ref_timeout} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_status: got %b required 00000", {cur_bank, busy, overrun, ref_timeout});
    end
    n_cmp++;
    if (state_dbg !== RS_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d required IDLE", state_dbg);
    end
    rst = 1'b1;
    step();
  endtask

  // First request lands 17 edges after enabling the timer.
  task automatic test_first_request();
    int n;
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (start_sr == 4'b0 && n < 40);
    n_cmp++;
    if (n !== 17) begin
      n_err++;
      $display("FAIL first_latency: start_sr after %0d cycles, required 17", n);
    end
    n_cmp++;
    if ({start_sr, ref_en_current, ref_en_old} !== {4'b0001, 4'b0001, 4'b1000}) begin
      n_err++;
      $display("FAIL first_enables: got %b_%b_%b required 0001_0001_1000", start_sr, ref_en_current, ref_en_old);
    end
    n_cmp++;
    if (busy !== 1'b1 || cur_bank !== 2'd0) begin
      n_err++;
      $display("FAIL first_busy: busy=%b cur_bank=%0d required 1/0", busy, cur_bank);
    end
  endtask

  // Bank 0 answers after 128 REFRESH cycles; the next round targets bank 1.
  task automatic test_done_release();
    step();
    n_cmp++;
    if (state_dbg !== RS_REFRESH || start_sr !== 4'b0 || ref_en_current !== 4'b0001 || ref_en_old !== 4'b1000) begin
      n_err++;
      $display("FAIL refresh_hold: state=%0d sr=%b cur=%b old=%b required REFRESH/0000/0001/1000", state_dbg, start_sr, ref_en_current, ref_en_old);
    end
    repeat (127) step();
    n_cmp++;
    if (state_dbg !== RS_REFRESH) begin
      n_err++;
      $display("FAIL refresh_128: state=%0d required REFRESH", state_dbg);
    end
    ref_done = 4'b0001;
    step();
    ref_done = 4'b0;
    n_cmp++;
    if ({ref_en_current, ref_en_old, busy} !== 9'b0 || state_dbg !== RS_IDLE) begin
      n_err++;
      $display("FAIL done_release: cur=%b old=%b busy=%b state=%0d required all 0 / IDLE", ref_en_current, ref_en_old, busy, state_dbg);
    end
    n_cmp++;
    if (cur_bank !== 2'd1) begin
      n_err++;
      $display("FAIL done_advance: cur_bank=%0d required 1", cur_bank);
    end
    wait_start("second");
    n_cmp++;
    if (start_sr !== 4'b0010 || ref_en_old !== 4'b0001) begin
      n_err++;
      $display("FAIL second_round: sr=%b old=%b required 0010/0001", start_sr, ref_en_old);
    end
  endtask

  task automatic do_round(input int b, input int o, input int d);
    logic [3:0] eb;
    logic [3:0] eo;
    eb = 4'b0001 << b;
    eo = 4'b0001 << o;
    n_cmp++;
    if (state_dbg !== RS_START || start_sr !== eb || ref_en_old !== eo || cur_bank !== 2'(b)) begin
      n_err++;
      $display("FAIL round%0d_start: state=%0d sr=%b old=%b bank=%0d required START/%b/%b/%0d", b, state_dbg, start_sr, ref_en_old, cur_bank, eb, eo, b);
    end
    step();
    repeat (d - 1) step();
    ref_done = eb;
    step();
    ref_done = 4'b0;
    n_cmp++;
    if (state_dbg !== RS_IDLE || ref_en_current !== 4'b0 || ref_en_old !== 4'b0) begin
      n_err++;
      $display("FAIL round%0d_end: state=%0d cur=%b old=%b required IDLE/0000/0000", b, state_dbg, ref_en_current, ref_en_old);
    end
    n_cmp++;
    if (cur_bank !== 2'((b + 1) % 4)) begin
      n_err++;
      $display("FAIL round%0d_wrap: cur_bank=%0d required %0d", b, cur_bank, (b + 1) % 4);
    end
    wait_start("round");
  endtask

  // Remaining rounds 1,2,3,0 with short replies, including the wrap to bank 0.
  task automatic test_rounds();
    do_round(1, 0, 3);
    do_round(2, 1, 1);
    do_round(3, 2, 5);
    do_round(0, 3, 2);
    n_cmp++;
    if (overlap_err !== 0) begin
      n_err++;
      $display("FAIL enable_overlap: %0d violations required 0", overlap_err);
    end
  endtask

  // Bank 1 never answers: 140 REFRESH cycles then abort; clr_err in the
  // abort cycle loses to the set.
  task automatic test_timeout();
    int n;
    enable = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || ref_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL pre_clear: overrun=%b ref_timeout=%b required 0/0", overrun, ref_timeout);
    end
    enable = 1'b1;
    n = 0;
    while (state_dbg == RS_REFRESH && n < 200) begin
      n++;
      if (n == 140) begin
        n_cmp++;
        if (overrun !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_set: overrun=%b required 1", overrun);
        end
        clr_err = 1'b1;
      end
      step();
    end
    clr_err = 1'b0;
    n_cmp++;
    if (n !== 140) begin
      n_err++;
      $display("FAIL timeout_len: REFRESH lasted %0d cycles required 140", n);
    end
    n_cmp++;
    if (ref_timeout !== 1'b1 || cur_bank !== 2'd2 || ref_en_current !== 4'b0) begin
      n_err++;
      $display("FAIL timeout_abort: ref_timeout=%b bank=%0d cur=%b required 1/2/0000", ref_timeout, cur_bank, ref_en_current);
    end
    enable = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || ref_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL clr_err: overrun=%b ref_timeout=%b required 0/0", overrun, ref_timeout);
    end
  endtask

  // Asynchronous reset in the middle of a REFRESH, then a fresh start.
  task automatic test_reset_mid();
    int n;
    enable = 1'b1;
    wait_start("pre_reset");
    repeat (6) step();
    n_cmp++;
    if (busy !== 1'b1 || ref_en_current !== 4'b0100) begin
      n_err++;
      $display("FAIL pre_reset_busy: busy=%b cur=%b required 1/0100", busy, ref_en_current);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({start_sr, ref_en_current, ref_en_old, busy, cur_bank} !== 15'b0 || state_dbg !== RS_IDLE) begin
      n_err++;
      $display("FAIL async_reset: outs=%b state=%0d required 0/IDLE", {start_sr, ref_en_current, ref_en_old, busy, cur_bank}, state_dbg);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (start_sr == 4'b0 && n < 40);
    n_cmp++;
    if (n !== 17 || start_sr !== 4'b0001 || ref_en_old !== 4'b1000) begin
      n_err++;
      $display("FAIL restart: after %0d cycles sr=%b old=%b required 17/0001/1000", n, start_sr, ref_en_old);
    end
  endtask

  // ref_done from a non-target bank must not end the round.
  task automatic test_ignore_other();
    step();
    ref_done = 4'b0100;
    repeat (10) step();
    n_cmp++;
    if (state_dbg !== RS_REFRESH || ref_en_current !== 4'b0001) begin
      n_err++;
      $display("FAIL ignore_other: state=%0d cur=%b required REFRESH/0001", state_dbg, ref_en_current);
    end
    ref_done = 4'b0101;
    step();
    ref_done = 4'b0;
    n_cmp++;
    if (state_dbg !== RS_IDLE || cur_bank !== 2'd1) begin
      n_err++;
      $display("FAIL own_done: state=%0d bank=%0d required IDLE/1", state_dbg, cur_bank);
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_done_release();
    test_rounds();
    test_timeout();
    test_reset_mid();
    test_ignore_other();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
